// File: rtl/cp0_reg_if.sv
// rtl/cp0_reg_if.sv - mtc0/mfc0 register access bus for cp0_reg
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, output waddr_i, output raddr_i, output data_i, input data_o);
    modport slave  (input we_i, input waddr_i, input raddr_i, input data_i, output data_o);
endinterface

// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - MIPS CP0 subset: BadVAddr, Count, Compare, Status, Cause, EPC
module cp0_reg (
    input  logic        clk,
    input  logic        resetn,
    cp0_reg_if.slave    bus,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] EXC_NONE     = 32'h00;
    localparam logic [31:0] EXC_INT      = 32'h01;
    localparam logic [31:0] EXC_ADEL     = 32'h04;
    localparam logic [31:0] EXC_ADES     = 32'h05;
    localparam logic [31:0] EXC_ERET     = 32'h0e;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        compare_hit;

    assign compare_hit = (compare_q != 32'd0) && (count_q == compare_q);

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        tick_d     = ~tick_q;
        count_d    = tick_q ? count_q + 32'd1 : count_q;

        cause_d[15:10] = int_i;
        if (compare_hit)
            cause_d[30] = 1'b1;

        if (except_type_i == EXC_NONE) begin
            if (bus.we_i) begin
                case (bus.waddr_i)
                    REG_COUNT: begin
                        count_d = bus.data_i;
                        tick_d  = 1'b0;
                    end
                    REG_COMPARE: begin
                        compare_d   = bus.data_i;
                        cause_d[30] = 1'b0;
                    end
                    REG_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);
                    REG_CAUSE:   cause_d[9:8] = bus.data_i[9:8];
                    REG_EPC:     epc_d = bus.data_i;
                    default: ;
                endcase
            end
        end else if (except_type_i == EXC_ERET) begin
            status_d[1] = 1'b0;
        end else begin
            status_d[1]  = 1'b1;
            cause_d[6:2] = (except_type_i == EXC_INT) ? 5'd0 : except_type_i[4:0];
            // A nested exception keeps the EPC/BD of the outermost one.
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_d[31] = is_in_delayslot_i;
            end
            if (except_type_i == EXC_ADEL || except_type_i == EXC_ADES)
                badvaddr_d = badvaddr_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            tick_q     <= 1'b0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        bus.data_o = 32'd0;
        case (bus.raddr_i)
            REG_BADVADDR: bus.data_o = badvaddr_q;
            REG_COUNT:    bus.data_o = count_q;
            REG_COMPARE:  bus.data_o = compare_q;
            REG_STATUS:   bus.data_o = status_q;
            REG_CAUSE:    bus.data_o = cause_q;
            REG_EPC:      bus.data_o = epc_q;
            default: ;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = cause_q[30];
endmodule

// File: tb/tb_cp0_reg.sv
// tb/tb_cp0_reg.sv - randomized bench for cp0_reg against a field-level CP0 model
module tb_cp0_reg;
    logic        clk;
    logic        resetn;
    logic [5:0]  int_in;
    logic [31:0] et;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bva_in;
    logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    int n_checks;
    int n_fail;

    cp0_reg_if bus ();

    cp0_reg dut (
        .clk               (clk),
        .resetn            (resetn),
        .bus               (bus),
        .int_i             (int_in),
        .except_type_i     (et),
        .pc_i              (pc),
        .is_in_delayslot_i (ds),
        .badvaddr_i        (bva_in),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .badvaddr_o        (badvaddr_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .timer_int_o       (timer_int_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state, one variable per architectural field.
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [7:0]  m_im;
    logic [5:0]  m_ip_hw;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bva, m_cnt, m_cmp;
    int          m_edges_since_load;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_cnt;
            5'd11:   return m_cmp;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_im = 0; m_ip_hw = 0; m_ip_sw = 0;
        m_exc = 0; m_epc = 0; m_bva = 0; m_cnt = 0; m_cmp = 0;
        m_edges_since_load = 0;
    endtask

    task automatic check_all();
        check("status", status_o, m_status());
        check("cause", cause_o, m_cause());
        check("epc", epc_o, m_epc);
        check("badvaddr", badvaddr_o, m_bva);
        check("count", count_o, m_cnt);
        check("compare", compare_o, m_cmp);
        check("timer_int", {31'd0, timer_int_o}, {31'd0, m_ti});
        check("data_o", bus.data_o, m_read(bus.raddr_i));
    endtask

    // One clock edge: next state from the pre-edge inputs, then compare 1 time unit later.
    task automatic cycle();
        logic        n_exl, n_ie, n_bd, n_ti;
        logic [7:0]  n_im;
        logic [1:0]  n_ip_sw;
        logic [4:0]  n_exc;
        logic [31:0] n_epc, n_bva, n_cnt, n_cmp;
        int          n_edges;
        n_exl = m_exl; n_ie = m_ie; n_bd = m_bd; n_ti = m_ti; n_im = m_im; n_ip_sw = m_ip_sw;
        n_exc = m_exc; n_epc = m_epc; n_bva = m_bva; n_cmp = m_cmp;
        // Count advances on every second edge after reset or a load.
        n_edges = m_edges_since_load + 1;
        n_cnt   = (m_edges_since_load % 2 == 1) ? m_cnt + 32'd1 : m_cnt;
        if (m_cmp != 0 && m_cnt == m_cmp) n_ti = 1;
        if (et == 0) begin
            if (bus.we_i) begin
                if (bus.waddr_i == 9)  begin n_cnt = bus.data_i; n_edges = 0; end
                if (bus.waddr_i == 11) begin n_cmp = bus.data_i; n_ti = 0; end
                if (bus.waddr_i == 12) begin n_im = bus.data_i[15:8]; n_exl = bus.data_i[1]; n_ie = bus.data_i[0]; end
                if (bus.waddr_i == 13) n_ip_sw = bus.data_i[9:8];
                if (bus.waddr_i == 14) n_epc = bus.data_i;
            end
        end else if (et == 32'h0e) begin
            n_exl = 0;
        end else begin
            n_exl = 1;
            n_exc = (et == 32'h01) ? 5'd0 : et[4:0];
            if (!m_exl) begin
                n_epc = ds ? pc - 32'd4 : pc;
                n_bd  = ds;
            end
            if (et == 32'h04 || et == 32'h05) n_bva = bva_in;
        end
        m_ip_hw = int_in;
        @(posedge clk);
        #1;
        m_exl = n_exl; m_ie = n_ie; m_bd = n_bd; m_ti = n_ti; m_im = n_im; m_ip_sw = n_ip_sw;
        m_exc = n_exc; m_epc = n_epc; m_bva = n_bva; m_cnt = n_cnt; m_cmp = n_cmp;
        m_edges_since_load = n_edges;
        check_all();
    endtask

    task automatic idle();
        bus.we_i = 0; et = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1; bus.waddr_i = a; bus.data_i = d; et = 0;
        cycle();
        idle();
    endtask

    task automatic except(input logic [31:0] t, input logic [31:0] p, input logic d, input logic [31:0] b);
        et = t; pc = p; ds = d; bva_in = b;
        cycle();
        idle();
    endtask

    logic [4:0]  addr_pool [7];
    logic [31:0] exc_pool  [10];

    initial begin
        bool_init();
    end

    task automatic bool_init();
        bit seen;
        logic [31:0] epc_hold;
        n_checks = 0;
        n_fail   = 0;
        addr_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        exc_pool  = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c, 32'h0e, 32'h13, 32'h20};
        resetn = 0; int_in = 0; et = 0; pc = 0; ds = 0; bva_in = 0;
        bus.we_i = 0; bus.waddr_i = 0; bus.raddr_i = 5'd12; bus.data_i = 0;
        model_reset();
        #12;
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_count", count_o, 32'd0);
        check("rst_cause", cause_o, 32'd0);
        check("rst_ti", {31'd0, timer_int_o}, 32'd0);
        #5 resetn = 1;

        // Idle after reset: first increment on the second edge.
        cycle();
        check("cnt_edge1", count_o, 32'd0);
        cycle();
        check("cnt_edge2", count_o, 32'd1);
        repeat (8) cycle();
        check("cnt_10", count_o, 32'd5);
        check("status_idle", status_o, 32'h0040_0000);
        check("rd_status", bus.data_o, 32'h0040_0000);

        // Timer interrupt.
        mtc0(5'd11, 32'd8);
        mtc0(5'd9, 32'd6);
        check("cnt_load", count_o, 32'd6);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (timer_int_o) seen = 1;
        end
        check("ti_rise", {31'd0, seen}, 32'd1);
        check("ti_cnt", count_o, 32'd8);
        repeat (4) cycle();
        check("ti_hold", {31'd0, timer_int_o}, 32'd1);
        mtc0(5'd11, 32'h20);
        check("ti_clear", {31'd0, timer_int_o}, 32'd0);

        // Exception in delay slot, then nested AdEL and eret.
        except(32'h0a, 32'hbfc0_0100, 1'b1, 32'd0);
        check("exc_epc", epc_o, 32'hbfc0_00fc);
        check("exc_bd", {31'd0, cause_o[31]}, 32'd1);
        check("exc_code", {27'd0, cause_o[6:2]}, 32'd10);
        check("exc_exl", {31'd0, status_o[1]}, 32'd1);
        epc_hold = epc_o;
        except(32'h04, 32'h8000_0040, 1'b0, 32'h0000_0003);
        check("adel_bva", badvaddr_o, 32'h3);
        check("adel_code", {27'd0, cause_o[6:2]}, 32'd4);
        check("adel_epc", epc_o, epc_hold);
        except(32'h0e, 32'd0, 1'b0, 32'd0);
        check("eret_exl", {31'd0, status_o[1]}, 32'd0);

        // Exception suppresses a simultaneous mtc0.
        bus.we_i = 1; bus.waddr_i = 5'd12; bus.data_i = 32'hffff_ffff;
        except(32'h08, 32'h1000, 1'b0, 32'd0);
        check("sup_status", status_o, 32'h0040_0002);
        check("sup_code", {27'd0, cause_o[6:2]}, 32'd8);

        int_in = 6'b000001;
        mtc0(5'd12, 32'hffff_ffff);
        check("wr_status", status_o, 32'h0040_ff03);
        check("int_ip", {31'd0, cause_o[10]}, 32'd1);
        int_in = 0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addr_pool[$urandom_range(0, 5)];
            bus.we_i    = ($urandom_range(0, 2) == 0);
            bus.waddr_i = ($urandom_range(0, 5) == 0) ? 5'($urandom) : addr_pool[$urandom_range(0, 5)];
            bus.data_i  = $urandom;
            if (bus.waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
                bus.data_i = m_cnt + 32'($urandom_range(0, 6));
            if (bus.waddr_i == 5'd9 && $urandom_range(0, 3) == 0)
                bus.data_i = 32'hffff_fffe;
            int_in = 6'($urandom);
            et     = ($urandom_range(0, 9) < 7) ? 32'd0 : exc_pool[$urandom_range(0, 9)];
            pc     = $urandom;
            ds     = 1'($urandom);
            bva_in = $urandom;
            cycle();
        end
        idle();

        // Asynchronous reset between edges.
        #2 resetn = 0;
        #1;
        model_reset();
        check("arst_count", count_o, 32'd0);
        check("arst_status", status_o, 32'h0040_0000);
        check("arst_epc", epc_o, 32'd0);
        #10 resetn = 1;
        @(negedge clk);
        cycle();
        cycle();
        check("post_arst_cnt", count_o, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    endtask
endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 we_i  in  1  mtc0 write enable.
REQ-004 waddr_i  in  5  mtc0 destination register number.
REQ-005 raddr_i  in  5  mfc0 source register number.
REQ-006 data_i  in  32  mtc0 write data.
REQ-007 int_i  in  6  external hardware interrupt lines.
REQ-008 except_type_i  in  32  committed exception code from the memory stage: 0x01 Int, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0a RI, 0x0c Ov, 0x0e eret, 0x00 none.
REQ-009 pc_i  in  32  PC of the excepting instruction.
REQ-010 is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot.
REQ-011 badvaddr_i  in  32  faulting address for AdEL/AdES.
REQ-012 data_o  out  32  mfc0 read data.
REQ-013 status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32 each  current register values.
REQ-014 timer_int_o  out  1  timer interrupt pending (equals Cause[30]).

Function
REQ-015 Registers, by number: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14; any other raddr_i SHALL read 0.
REQ-016 data_o SHALL be combinational from raddr_i and the current register state, with no write bypass.
REQ-017 Count SHALL increment by 1 every second clock, using an internal tick bit that toggles each cycle; Count SHALL wrap from 0xFFFF_FFFF to 0.
REQ-018 An mtc0 to Count SHALL load data_i and clear the tick bit, and that cycle SHALL NOT increment Count.
REQ-019 When Compare != 0 and Count == Compare, Cause[30] (TI) SHALL be set the next cycle and SHALL stay set until Compare is written.
REQ-020 An mtc0 to Compare SHALL load data_i and clear TI in the same edge; clearing SHALL win over a simultaneous match.
REQ-021 Cause[15:10] SHALL be loaded from int_i every cycle (one-cycle registered copy).
REQ-022 mtc0 writable fields: Status[15:8] (IM), Status[1] (EXL) and Status[0] (IE); Cause[9:8] (software IP); all of EPC, Count and Compare. All other bits, and all of BadVAddr, SHALL ignore writes.
REQ-023 Status[22] (BEV) SHALL read 1; all other non-writable Status and Cause bits SHALL read 0, except the hardware-set Cause bits in REQ-019, REQ-021, REQ-024 and REQ-026.
REQ-024 Exception entry (except_type_i is nonzero and not 0x0e):
- Status[1] SHALL be set to 1.
- Cause[6:2] (ExcCode) SHALL be set to 0 for type 0x01, and to except_type_i[4:0] otherwise.
- If Status[1] was 0: EPC SHALL be set to pc_i - 4 and Cause[31] (BD) to 1 when is_in_delayslot_i is 1; otherwise EPC SHALL be set to pc_i and BD to 0.
- If Status[1] was already 1: EPC and BD SHALL be left unchanged.
REQ-025 For except_type_i 0x04 or 0x05, BadVAddr SHALL load badvaddr_i; for all other types BadVAddr SHALL hold its value.
REQ-026 For except_type_i 0x0e (eret), Status[1] SHALL be cleared; no other register changes.
REQ-027 Any nonzero except_type_i SHALL suppress an mtc0 write in the same cycle; Count increment, TI set and the int_i sampling SHALL continue regardless.
REQ-028 Unlisted nonzero except_type_i values SHALL be treated as an exception entry with ExcCode = except_type_i[4:0].

Reset
REQ-029 While resetn is 0, registers SHALL reset asynchronously to: Status 0x0040_0000; Cause, EPC, BadVAddr, Count and Compare 0; tick bit 0; timer_int_o 0.
REQ-030 On reset release, the first Count increment SHALL occur on the second rising edge.

Verification
REQ-031 Reset, then 10 cycles idle -> Count = 5, Status = 0x0040_0000, data_o for raddr 12 = 0x0040_0000.
REQ-032 mtc0 Compare = 8, mtc0 Count = 6 -> TI rises when Count reaches 8, and timer_int_o stays 1 until mtc0 Compare = 0x20 clears it in that edge.
REQ-033 except_type 0x0a, pc 0xbfc0_0100, delayslot 1, EXL 0 -> EPC = 0xbfc0_00fc, Cause[31] = 1, Cause[6:2] = 10, Status[1] = 1.
REQ-034 With EXL 1, except_type 0x04, badvaddr 0x0000_0003 -> BadVAddr = 0x3, ExcCode = 4, EPC unchanged; then except_type 0x0e -> Status[1] = 0.
REQ-035 mtc0 Status = 0xFFFF_FFFF in the same cycle as except_type 0x08 -> write dropped: Status = 0x0040_0002, ExcCode = 8.
REQ-036 mtc0 Status = 0xFFFF_FFFF with no exception -> Status = 0x0040_FF03; int_i = 6'b000001 -> Cause[10] = 1 one cycle later.
